// File: rtl/ahb_burst_master_if.sv
// ---------------------------------------------------------------------------
// ahb_burst_master_if
//
// Bundles the core-side fetch request/response handshake and the AHB-Lite
// read-master signals of ahb_burst_master into a single interface.
//
// Signals:
//   req_valid/req_ready/req_addr/req_burst : fetch request from the core side
//   haddr/htrans/hburst/hwrite/hsize       : AHB address-phase outputs
//   hrdata/hready/hresp                    : AHB data-phase inputs from slave
//   rsp_valid/rsp_data/rsp_offset/
//   rsp_last/rsp_err                       : per-beat read response
//
// Modports:
//   master : the view used by ahb_burst_master itself
//   slave  : the opposite view (requester + AHB slave side)
// ---------------------------------------------------------------------------
interface ahb_burst_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [2:0]            req_burst;

  logic [ADDR_WIDTH-1:0] haddr;
  logic [1:0]            htrans;
  logic [2:0]            hburst;
  logic                  hwrite;
  logic [2:0]            hsize;
  logic [DATA_WIDTH-1:0] hrdata;
  logic                  hready;
  logic                  hresp;

  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic [3:0]            rsp_offset;
  logic                  rsp_last;
  logic                  rsp_err;

  modport master (
    input  req_valid, req_addr, req_burst,
    input  hrdata, hready, hresp,
    output req_ready,
    output haddr, htrans, hburst, hwrite, hsize,
    output rsp_valid, rsp_data, rsp_offset, rsp_last, rsp_err
  );

  modport slave (
    output req_valid, req_addr, req_burst,
    output hrdata, hready, hresp,
    input  req_ready,
    input  haddr, htrans, hburst, hwrite, hsize,
    input  rsp_valid, rsp_data, rsp_offset, rsp_last, rsp_err
  );

endinterface

// File: rtl/ahb_burst_master.sv
// ---------------------------------------------------------------------------
// ahb_burst_master
//
// AHB-Lite read initiator for instruction fetches. Accepts one request at a
// time (SINGLE or WRAP4), drives NONSEQ/SEQ address phases with 4-beat wrap
// addressing, follows the pipelined data phases under hready stalls and
// returns each beat with its in-line byte offset.
//
// Ports:
//   clk  : clock
//   rst  : asynchronous active-high reset
//   bus  : ahb_burst_master_if.master
//            request  : req_valid, req_ready, req_addr, req_burst
//            AHB      : haddr, htrans, hburst, hwrite, hsize,
//                       hrdata, hready, hresp
//            response : rsp_valid, rsp_data, rsp_offset, rsp_last, rsp_err
//
// Build option:
//   AHB_ERR_ABORT_EN - when defined, an ERROR response cancels the rest of
//   the burst and is reported with rsp_err/rsp_last. When undefined, hresp
//   is ignored and every burst runs all of its beats.
// ---------------------------------------------------------------------------
module ahb_burst_master #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic                clk,
  input logic                rst,
  ahb_burst_master_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [1:0] TRANS_IDLE   = 2'b00;
  localparam logic [1:0] TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ    = 2'b11;

  localparam logic [2:0] BURST_SINGLE = 3'd0;
  localparam logic [2:0] BURST_WRAP4  = 3'd2;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] haddr_q;
  logic [1:0]            htrans_q;
  logic [2:0]            hburst_q;
  logic                  req_ready_q;

  // Number of address phases placed on the bus so far, including the one
  // currently being driven.
  logic [2:0]            issued_q;

  // Bookkeeping for the beat that currently sits in its data phase.
  logic                  dataPending_q;
  logic [3:0]            dataOffset_q;
  logic                  dataLast_q;

  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic [3:0]            rsp_offset_q;
  logic                  rsp_last_q;
  logic                  rsp_err_q;

  logic [2:0]            reqBurstNorm;
  logic [ADDR_WIDTH-1:0] reqAddrAligned;
  logic [2:0]            totalBeats;
  logic                  allIssued;
  logic [ADDR_WIDTH-1:0] haddr_d;
  logic                  errStart;
  logic                  errDone;

  // Anything other than WRAP4 is handled as a SINGLE transfer.
  assign reqBurstNorm   = (bus.req_burst == BURST_WRAP4) ? BURST_WRAP4 : BURST_SINGLE;
  assign reqAddrAligned = {bus.req_addr[ADDR_WIDTH-1:2], 2'b00};

  assign totalBeats = (hburst_q == BURST_WRAP4) ? 3'd4 : 3'd1;
  assign allIssued  = (issued_q == totalBeats);

  // Next wrap address: the 16-byte line base stays fixed and only the word
  // offset advances, wrapping from 0xC back to 0x0.
  assign haddr_d = {haddr_q[ADDR_WIDTH-1:4], (haddr_q[3:0] + 4'h4) & 4'hC};

`ifdef AHB_ERR_ABORT_EN
  // First ERROR cycle (hready low) cancels the pending address phase; the
  // second cycle (hready high) completes the failed beat.
  assign errStart = dataPending_q & bus.hresp & ~bus.hready;
  assign errDone  = dataPending_q & bus.hresp &  bus.hready;

  logic unusedAddrBits;
  assign unusedAddrBits = ^bus.req_addr[1:0];
`else
  assign errStart = 1'b0;
  assign errDone  = 1'b0;

  logic unusedInputs;
  assign unusedInputs = ^{bus.req_addr[1:0], bus.hresp};
`endif

  // Single control process: the FSM, the address-phase generator, the
  // data-phase tracker and the response registers all advance together so
  // every bus-visible output is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      haddr_q       <= '0;
      htrans_q      <= TRANS_IDLE;
      hburst_q      <= BURST_SINGLE;
      req_ready_q   <= 1'b1;
      issued_q      <= 3'd0;
      dataPending_q <= 1'b0;
      dataOffset_q  <= 4'h0;
      dataLast_q    <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_offset_q  <= 4'h0;
      rsp_last_q    <= 1'b0;
      rsp_err_q     <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      rsp_last_q  <= 1'b0;
      rsp_err_q   <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            haddr_q       <= reqAddrAligned;
            htrans_q      <= TRANS_NONSEQ;
            hburst_q      <= reqBurstNorm;
            issued_q      <= 3'd1;
            dataPending_q <= 1'b0;
            req_ready_q   <= 1'b0;
            state_q       <= BUS;
          end
        end

        default: begin
          if (errStart) begin
            // Withdraw the address phase that has not yet been accepted.
            htrans_q <= TRANS_IDLE;
            state_q  <= DRAIN;
          end else if (bus.hready) begin
            // Retire the beat in its data phase, if any.
            if (dataPending_q) begin
              rsp_valid_q  <= 1'b1;
              rsp_data_q   <= bus.hrdata;
              rsp_offset_q <= dataOffset_q;
              rsp_last_q   <= dataLast_q | errDone;
              rsp_err_q    <= errDone;
            end

            if (errDone || state_q == DRAIN) begin
              // Final beat returned: the bus is idle again, and the next
              // request can only start its NONSEQ one cycle later.
              htrans_q      <= TRANS_IDLE;
              dataPending_q <= 1'b0;
              req_ready_q   <= 1'b1;
              state_q       <= IDLE;
            end else begin
              // The current address phase moves into its data phase.
              dataPending_q <= 1'b1;
              dataOffset_q  <= haddr_q[3:0];
              dataLast_q    <= allIssued;
              if (!allIssued) begin
                haddr_q  <= haddr_d;
                htrans_q <= TRANS_SEQ;
                issued_q <= issued_q + 3'd1;
              end else begin
                htrans_q <= TRANS_IDLE;
                state_q  <= DRAIN;
              end
            end
          end
        end
      endcase
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.haddr      = haddr_q;
  assign bus.htrans     = htrans_q;
  assign bus.hburst     = hburst_q;
  assign bus.hwrite     = 1'b0;
  assign bus.hsize      = 3'b010;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_data   = rsp_data_q;
  assign bus.rsp_offset = rsp_offset_q;
  assign bus.rsp_last   = rsp_last_q;
  assign bus.rsp_err    = rsp_err_q;

endmodule

// File: tb/tb_ahb_burst_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_burst_master
//
// Directed bench for ahb_burst_master. Stimulus drives the request and the
// AHB slave side cycle by cycle and checks the address phases directly;
// every expected read beat (cycle, data, offset, last, err) is queued when
// the request is issued and a separate monitor pops and compares whenever
// rsp_valid is seen. The slave returns hrdata = 0xDA7A0000 | edge number, so
// the expected data of a beat follows from the edge at which it completes.
// ---------------------------------------------------------------------------
module tb_ahb_burst_master;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [3:0]  off;
    logic        last;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   errors;
  int   checks;
  exp_t expQ[$];

  logic [31:0] wrapAddr [3];

  ahb_burst_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ahb_burst_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1, "[TB] timeout");
  end

  // Scoreboard monitor: one comparison per returned beat.
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpectedRsp: got beat at cycle %0d offset=%h last=%b err=%b, required none",
                 cyc, bus.rsp_offset, bus.rsp_last, bus.rsp_err);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        if (e.cyc != cyc || e.data != bus.rsp_data || e.off != bus.rsp_offset ||
            e.last != bus.rsp_last || e.err != bus.rsp_err) begin
          errors++;
          $display("[TB] FAIL rspBeat: got cyc=%0d data=%h off=%h last=%b err=%b, required cyc=%0d data=%h off=%h last=%b err=%b",
                   cyc, bus.rsp_data, bus.rsp_offset, bus.rsp_last, bus.rsp_err,
                   e.cyc, e.data, e.off, e.last, e.err);
        end
      end
    end
  end

  // Advance one clock edge with the given slave response, then settle.
  task automatic tick(input logic rdy, input logic resp);
    bus.hready = rdy;
    bus.hresp  = resp;
    bus.hrdata = 32'hDA7A_0000 | (cyc + 1);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expectBeat(input int c, input logic [3:0] off, input logic last, input logic err);
    exp_t e;
    e.cyc  = c;
    e.data = 32'hDA7A_0000 | c;
    e.off  = off;
    e.last = last;
    e.err  = err;
    expQ.push_back(e);
  endtask

  // Present one request for a single edge; returns the acceptance edge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [2:0] burst, output int acc);
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    bus.req_burst = burst;
    checkOutput("reqReadyBeforeAccept", {31'd0, bus.req_ready}, 32'd1);
    tick(1'b1, 1'b0);
    acc = cyc;
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int a;
    cyc    = 0;
    errors = 0;
    checks = 0;
    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_burst = 3'd0;
    bus.hrdata    = '0;
    bus.hready    = 1'b1;
    bus.hresp     = 1'b0;

    // Reset state
    #1;
    checkOutput("resetHtrans",   {30'd0, bus.htrans}, 32'd0);
    checkOutput("resetHaddr",    bus.haddr, 32'd0);
    checkOutput("resetReqReady", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("resetRspValid", {31'd0, bus.rsp_valid}, 32'd0);
    checkOutput("hwriteConst",   {31'd0, bus.hwrite}, 32'd0);
    checkOutput("hsizeConst",    {29'd0, bus.hsize}, 32'd2);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    rst = 1'b0;
    tick(1'b1, 1'b0);

    // SINGLE at 0x1007: aligned to 0x1004, beat at +2
    $display("[TB] SINGLE 0x1007");
    applyStimulus(32'h1007, 3'd0, a);
    expectBeat(a + 2, 4'h4, 1'b1, 1'b0);
    checkOutput("singleHaddr",    bus.haddr, 32'h1004);
    checkOutput("singleNonseq",   {30'd0, bus.htrans}, 32'd2);
    checkOutput("singleHburst",   {29'd0, bus.hburst}, 32'd0);
    checkOutput("singleReqReady", {31'd0, bus.req_ready}, 32'd0);
    tick(1'b1, 1'b0);
    checkOutput("singleIdleAfter", {30'd0, bus.htrans}, 32'd0);
    tick(1'b1, 1'b0);
    checkOutput("singleReadyWithLast", {31'd0, bus.req_ready}, 32'd1);
    tick(1'b1, 1'b0);

    // WRAP4 at 0x2008: 8 -> C -> 0 -> 4
    $display("[TB] WRAP4 0x2008");
    wrapAddr[0] = 32'h200C;
    wrapAddr[1] = 32'h2000;
    wrapAddr[2] = 32'h2004;
    applyStimulus(32'h2008, 3'd2, a);
    expectBeat(a + 2, 4'h8, 1'b0, 1'b0);
    expectBeat(a + 3, 4'hC, 1'b0, 1'b0);
    expectBeat(a + 4, 4'h0, 1'b0, 1'b0);
    expectBeat(a + 5, 4'h4, 1'b1, 1'b0);
    checkOutput("wrapHaddr0",  bus.haddr, 32'h2008);
    checkOutput("wrapNonseq",  {30'd0, bus.htrans}, 32'd2);
    checkOutput("wrapHburst0", {29'd0, bus.hburst}, 32'd2);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0);
      checkOutput("wrapHaddrSeq", bus.haddr, wrapAddr[i]);
      checkOutput("wrapSeq",      {30'd0, bus.htrans}, 32'd3);
      checkOutput("wrapHburst",   {29'd0, bus.hburst}, 32'd2);
    end
    tick(1'b1, 1'b0);
    checkOutput("wrapIdleAfter", {30'd0, bus.htrans}, 32'd0);
    tick(1'b1, 1'b0);
    checkOutput("wrapReadyWithLast", {31'd0, bus.req_ready}, 32'd1);
    tick(1'b1, 1'b0);

    // WRAP4 at 0x3000 with two wait states: beats at +2,+5,+6,+7
    $display("[TB] WRAP4 0x3000 with stall");
    applyStimulus(32'h3000, 3'd2, a);
    expectBeat(a + 2, 4'h0, 1'b0, 1'b0);
    expectBeat(a + 5, 4'h4, 1'b0, 1'b0);
    expectBeat(a + 6, 4'h8, 1'b0, 1'b0);
    expectBeat(a + 7, 4'hC, 1'b1, 1'b0);
    tick(1'b1, 1'b0);
    checkOutput("stallHaddrBeat2", bus.haddr, 32'h3004);
    tick(1'b1, 1'b0);
    checkOutput("stallHaddrBeat3", bus.haddr, 32'h3008);
    tick(1'b0, 1'b0);
    checkOutput("stallHold1", bus.haddr, 32'h3008);
    tick(1'b0, 1'b0);
    checkOutput("stallHold2", bus.haddr, 32'h3008);
    checkOutput("stallHoldTrans", {30'd0, bus.htrans}, 32'd3);
    tick(1'b1, 1'b0);
    checkOutput("stallHaddrBeat4", bus.haddr, 32'h300C);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);

    // Back-to-back SINGLEs with req_valid held high
    $display("[TB] back-to-back SINGLE");
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h5010;
    bus.req_burst = 3'd0;
    tick(1'b1, 1'b0);
    a = cyc;
    bus.req_addr = 32'h5024;
    expectBeat(a + 2, 4'h0, 1'b1, 1'b0);
    expectBeat(a + 5, 4'h4, 1'b1, 1'b0);
    checkOutput("b2bFirstHaddr", bus.haddr, 32'h5010);
    tick(1'b1, 1'b0);
    checkOutput("b2bIdleInData", {30'd0, bus.htrans}, 32'd0);
    tick(1'b1, 1'b0);
    checkOutput("b2bIdleWithLast", {30'd0, bus.htrans}, 32'd0);
    checkOutput("b2bReadyWithLast", {31'd0, bus.req_ready}, 32'd1);
    tick(1'b1, 1'b0);
    bus.req_valid = 1'b0;
    checkOutput("b2bSecondHaddr",  bus.haddr, 32'h5024);
    checkOutput("b2bSecondNonseq", {30'd0, bus.htrans}, 32'd2);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);

    // WRAP4 at 0x4000 with an ERROR response on beat 2
    $display("[TB] WRAP4 0x4000 with ERROR on beat 2");
    applyStimulus(32'h4000, 3'd2, a);
    expectBeat(a + 2, 4'h0, 1'b0, 1'b0);
`ifdef AHB_ERR_ABORT_EN
    expectBeat(a + 4, 4'h4, 1'b1, 1'b1);
`else
    expectBeat(a + 4, 4'h4, 1'b0, 1'b0);
    expectBeat(a + 5, 4'h8, 1'b0, 1'b0);
    expectBeat(a + 6, 4'hC, 1'b1, 1'b0);
`endif
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b0, 1'b1);
`ifdef AHB_ERR_ABORT_EN
    checkOutput("errIdle2ndCycle", {30'd0, bus.htrans}, 32'd0);
`else
    checkOutput("errIgnoredSeq", {30'd0, bus.htrans}, 32'd3);
    checkOutput("errIgnoredHaddr", bus.haddr, 32'h4008);
`endif
    tick(1'b1, 1'b1);
`ifdef AHB_ERR_ABORT_EN
    checkOutput("errReadyAfter", {31'd0, bus.req_ready}, 32'd1);
    tick(1'b1, 1'b0);
    checkOutput("errNoMoreBeats", {30'd0, bus.htrans}, 32'd0);
`else
    checkOutput("errIgnoredBeat4", bus.haddr, 32'h400C);
    tick(1'b1, 1'b0);
    checkOutput("errIgnoredIdle", {30'd0, bus.htrans}, 32'd0);
`endif
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);

    // Asynchronous reset in the middle of a WRAP4: nothing is returned
    $display("[TB] reset mid-burst");
    applyStimulus(32'h6004, 3'd2, a);
    tick(1'b1, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("midRstHaddr",     bus.haddr, 32'd0);
    checkOutput("midRstHtrans",    {30'd0, bus.htrans}, 32'd0);
    checkOutput("midRstHburst",    {29'd0, bus.hburst}, 32'd0);
    checkOutput("midRstReqReady",  {31'd0, bus.req_ready}, 32'd1);
    checkOutput("midRstRspData",   bus.rsp_data, 32'd0);
    checkOutput("midRstRspOffset", {28'd0, bus.rsp_offset}, 32'd0);
    tick(1'b1, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick(1'b1, 1'b0);
    checkOutput("postRstReqReady", {31'd0, bus.req_ready}, 32'd1);
    checkOutput("postRstHtrans",   {30'd0, bus.htrans}, 32'd0);

    checkOutput("scoreboardEmpty", expQ.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
